program_loader: RTL and testbench

PROGRAM_LOADER -- requirements
Module: program_loader

---
 rtl/program_loader.sv | 179 +++++++++++++++++
 tb/tb_program_loader.sv | 429 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// program_loader: receives a byte-stream image (count header, 3-byte words, XOR checksum),
// writes 19-bit words into instruction memory and holds the CPU until a good image is loaded.
module program_loader (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        im_we,
    output logic [11:0] im_addr,
    output logic [18:0] im_wdata,
    output logic        cpu_hold,
    output logic        done,
    output logic        err
);

    // state | meaning
    // IDLE  | out of reset, waiting for start
    // HDR0  | expecting count[7:0]
    // HDR1  | expecting count[11:8]; upper nibble must be zero
    // WORD  | collecting three bytes per instruction word
    // CSUM  | expecting checksum byte
    // DONE  | image accepted, CPU released
    // ERR   | image rejected, CPU held
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HDR0 = 3'd1,
        HDR1 = 3'd2,
        WORD = 3'd3,
        CSUM = 3'd4,
        DONE = 3'd5,
        ERR  = 3'd6
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic [11:0] r_count;
    logic [11:0] r_word_idx;
    logic [1:0]  r_byte_idx;
    logic [7:0]  r_csum;
    logic [15:0] r_word_lo;
    logic        r_we;
    logic [11:0] r_addr;
    logic [18:0] r_wdata;

    logic        w_accept;
    logic        w_restart;
    logic        w_last_word;
    logic        w_word_done;
    logic [11:0] w_hdr_count;

    assign w_accept    = in_valid && in_ready;
    assign w_restart   = start && ((r_state == IDLE) || (r_state == DONE) || (r_state == ERR));
    assign w_last_word = (r_word_idx == (r_count - 12'd1));
    assign w_word_done = w_accept && (r_state == WORD) && (r_byte_idx == 2'd2);
    assign w_hdr_count = {in_data[3:0], r_count[7:0]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        cpu_hold     = 1'b1;
        done         = 1'b0;
        err          = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) w_state_next = HDR0;
            end
            HDR0: begin
                in_ready = 1'b1;
                if (in_valid) w_state_next = HDR1;
            end
            HDR1: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (in_data[7:4] != 4'd0)
                        w_state_next = ERR;
                    else if (w_hdr_count == 12'd0)
                        w_state_next = CSUM;
                    else
                        w_state_next = WORD;
                end
            end
            WORD: begin
                in_ready = 1'b1;
                if (in_valid && (r_byte_idx == 2'd2) && w_last_word) w_state_next = CSUM;
            end
            CSUM: begin
                in_ready = 1'b1;
                if (in_valid) w_state_next = (in_data == r_csum) ? DONE : ERR;
            end
            DONE: begin
                cpu_hold = 1'b0;
                done     = 1'b1;
                if (start) w_state_next = HDR0;
            end
            ERR: begin
                err = 1'b1;
                if (start) w_state_next = HDR0;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Header, indices and checksum; a restart only arrives when in_ready is low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count    <= 12'd0;
            r_word_idx <= 12'd0;
            r_byte_idx <= 2'd0;
            r_csum     <= 8'd0;
            r_word_lo  <= 16'd0;
        end else if (w_restart) begin
            r_count    <= 12'd0;
            r_word_idx <= 12'd0;
            r_byte_idx <= 2'd0;
            r_csum     <= 8'd0;
        end else if (w_accept) begin
            case (r_state)
                HDR0: begin
                    r_count[7:0] <= in_data;
                    r_csum       <= r_csum ^ in_data;
                end
                HDR1: begin
                    r_count[11:8] <= in_data[3:0];
                    r_csum        <= r_csum ^ in_data;
                    r_byte_idx    <= 2'd0;
                end
                WORD: begin
                    r_csum <= r_csum ^ in_data;
                    case (r_byte_idx)
                        2'd0: begin
                            r_word_lo[7:0] <= in_data;
                            r_byte_idx     <= 2'd1;
                        end
                        2'd1: begin
                            r_word_lo[15:8] <= in_data;
                            r_byte_idx      <= 2'd2;
                        end
                        default: begin
                            r_word_idx <= r_word_idx + 12'd1;
                            r_byte_idx <= 2'd0;
                        end
                    endcase
                end
                default: ;
            endcase
        end
    end

    // Write port is captured once per word so the next byte can land in r_word_lo meanwhile.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_we    <= 1'b0;
            r_addr  <= 12'd0;
            r_wdata <= 19'd0;
        end else begin
            r_we <= w_word_done;
            if (w_word_done) begin
                r_addr  <= r_word_idx;
                r_wdata <= {in_data[2:0], r_word_lo};
            end
        end
    end

    assign im_we    = r_we;
    assign im_addr  = r_addr;
    assign im_wdata = r_wdata;

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: randomized streams and valid stalls compared
// against a stream-level reference model of the loader image format.
module tb_program_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'd0;
    logic        in_ready;
    logic        im_we;
    logic [11:0] im_addr;
    logic [18:0] im_wdata;
    logic        cpu_hold;
    logic        done;
    logic        err;

    int checks = 0;
    int errors = 0;
    int overlap = 0;

    logic [7:0]  stream[$];
    logic [30:0] exp_q[$];
    logic [30:0] got_q[$];
    logic [30:0] ref_q[$];
    logic        exp_done;
    logic        exp_err;
    int          exp_n;

    program_loader dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .im_we    (im_we),
        .im_addr  (im_addr),
        .im_wdata (im_wdata),
        .cpu_hold (cpu_hold),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (im_we) got_q.push_back({im_addr, im_wdata});
    end

    // Image: count lo, count hi, 3*count word bytes, XOR of all previous bytes.
    task automatic build_stream(input int cnt, input bit corrupt);
        logic [11:0] c;
        logic [7:0]  b;
        logic [7:0]  x;
        c = cnt[11:0];
        stream.delete();
        stream.push_back(c[7:0]);
        stream.push_back({4'h0, c[11:8]});
        x = c[7:0] ^ {4'h0, c[11:8]};
        for (int i = 0; i < 3 * cnt; i++) begin
            b = 8'($urandom);
            stream.push_back(b);
            x = x ^ b;
        end
        if (corrupt) x = x ^ 8'($urandom_range(255, 1));
        stream.push_back(x);
    endtask

    task automatic run_model();
        int          cnt;
        int          p;
        logic [7:0]  x;
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [7:0]  b2;
        logic [11:0] wa;
        exp_q.delete();
        exp_done = 1'b0;
        exp_err  = 1'b0;
        b0 = stream[0];
        b1 = stream[1];
        if (b1 > 8'd15) begin
            exp_err = 1'b1;
            exp_n   = 2;
            return;
        end
        cnt = int'(b0) + 256 * int'(b1);
        x = b0 ^ b1;
        for (int w = 0; w < cnt; w++) begin
            p  = 2 + 3 * w;
            b0 = stream[p];
            b1 = stream[p + 1];
            b2 = stream[p + 2];
            wa = w[11:0];
            exp_q.push_back({wa, b2[2:0], b1, b0});
            x = x ^ b0 ^ b1 ^ b2;
        end
        p     = 2 + 3 * cnt;
        exp_n = p + 1;
        b0    = stream[p];
        if (b0 == x) exp_done = 1'b1;
        else         exp_err  = 1'b1;
    endtask

    task automatic pulse_start();
        got_q.delete();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drive(input int first, input int last, input int duty);
        int i;
        int guard;
        i = first;
        guard = 0;
        while (i < last && guard < 40000) begin
            @(negedge clk);
            in_data  = stream[i];
            in_valid = (int'($urandom_range(99)) < duty);
            #1;
            if (in_valid && in_ready) begin
                if (im_we) overlap++;
                i++;
            end
            guard++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (i != last) begin
            errors++;
            $display("FAIL drive_timeout: accepted %0d bytes, required %0d", i - first, last - first);
        end
    endtask

    task automatic settle();
        repeat (4) @(negedge clk);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Index of first differing write, -2 on count mismatch, -1 when identical.
    function automatic int write_diff(input logic [30:0] a[$], input logic [30:0] b[$]);
        if (a.size() != b.size()) return -2;
        foreach (a[k]) if (a[k] !== b[k]) return k;
        return -1;
    endfunction

    task automatic test_reset();
        #3;
        checks++;
        if ({in_ready, im_we, im_addr, im_wdata, cpu_hold, done, err} !==
            {1'b0, 1'b0, 12'd0, 19'd0, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_async: rdy/we/addr/wdata/hold/done/err=%b/%b/%h/%h/%b/%b/%b, required 0/0/000/00000/1/0/0",
                     in_ready, im_we, im_addr, im_wdata, cpu_hold, done, err);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        settle();
        checks++;
        if ({in_ready, im_we, cpu_hold, done, err} !== 5'b00100) begin
            errors++;
            $display("FAIL reset_idle: rdy/we/hold/done/err=%b%b%b%b%b, required 00100",
                     in_ready, im_we, cpu_hold, done, err);
        end
    endtask

    task automatic test_spec_vector();
        int d;
        logic [7:0] x;
        stream.delete();
        stream = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h7F, 8'hA5, 8'h05};
        x = 8'h00;
        foreach (stream[k]) x = x ^ stream[k];
        stream.push_back(x);
        run_model();
        pulse_start();
        checks++;
        if ({in_ready, cpu_hold, done, err} !== 4'b1100) begin
            errors++;
            $display("FAIL spec_hdr0: rdy/hold/done/err=%b%b%b%b, required 1100", in_ready, cpu_hold, done, err);
        end
        overlap = 0;
        drive(0, exp_n, 100);
        settle();
        d = write_diff(got_q, exp_q);
        checks++;
        if (d != -1) begin
            errors++;
            $display("FAIL spec_writes: %0d writes, first bad %0d, required %0d writes", got_q.size(), d, exp_q.size());
        end
        checks++;
        if (got_q.size() != 2 || got_q[0] !== {12'd0, 19'h00013} || got_q[1] !== {12'd1, 19'h5A57F}) begin
            errors++;
            $display("FAIL spec_words: got %0d writes, required addr0=00013 addr1=5A57F", got_q.size());
        end
        checks++;
        if ({done, err, cpu_hold, in_ready} !== 4'b1000) begin
            errors++;
            $display("FAIL spec_outcome: done/err/hold/rdy=%b%b%b%b, required 1000", done, err, cpu_hold, in_ready);
        end
        checks++;
        if ({im_we, im_addr, im_wdata} !== {1'b0, 12'd1, 19'h5A57F}) begin
            errors++;
            $display("FAIL spec_hold_bus: we/addr/wdata=%b/%h/%h, required 0/001/5a57f", im_we, im_addr, im_wdata);
        end
        checks++;
        if (overlap == 0) begin
            errors++;
            $display("FAIL spec_overlap: bytes accepted during im_we=%0d, required >0", overlap);
        end
    endtask

    task automatic test_zero_count();
        for (int t = 0; t < 2; t++) begin
            stream.delete();
            stream = '{8'h00, 8'h00, 8'h00};
            if (t == 1) stream[2] = 8'h01;
            run_model();
            pulse_start();
            drive(0, exp_n, 100);
            settle();
            checks++;
            if (got_q.size() != 0) begin
                errors++;
                $display("FAIL zero_count_writes[%0d]: %0d writes, required 0", t, got_q.size());
            end
            checks++;
            if ({done, err, cpu_hold, in_ready} !== {exp_done, exp_err, ~exp_done, 1'b0}) begin
                errors++;
                $display("FAIL zero_count_outcome[%0d]: done/err/hold/rdy=%b%b%b%b, required %b%b%b0",
                         t, done, err, cpu_hold, in_ready, exp_done, exp_err, ~exp_done);
            end
        end
    endtask

    task automatic test_bad_header();
        stream.delete();
        stream = '{8'h01, 8'h10};
        run_model();
        pulse_start();
        drive(0, exp_n, 100);
        settle();
        checks++;
        if ({err, done, cpu_hold, in_ready, got_q.size() == 0} !== 5'b10101) begin
            errors++;
            $display("FAIL bad_header: err/done/hold/rdy=%b%b%b%b writes=%0d, required 1010 writes=0",
                     err, done, cpu_hold, in_ready, got_q.size());
        end
    endtask

    task automatic test_stall();
        int d;
        build_stream(1, 1'b0);
        run_model();
        pulse_start();
        overlap = 0;
        drive(0, exp_n, 100);
        settle();
        ref_q = got_q;
        checks++;
        if (overlap == 0) begin
            errors++;
            $display("FAIL stall_overlap: csum byte accepted during im_we=%0d, required >0", overlap);
        end
        pulse_start();
        drive(0, exp_n, 30);
        settle();
        d = write_diff(got_q, ref_q);
        checks++;
        if (d != -1 || write_diff(got_q, exp_q) != -1) begin
            errors++;
            $display("FAIL stall_writes: %0d writes (diff %0d vs streamed), required %0d", got_q.size(), d, exp_q.size());
        end
        checks++;
        if ({done, err, cpu_hold} !== 3'b100) begin
            errors++;
            $display("FAIL stall_outcome: done/err/hold=%b%b%b, required 100", done, err, cpu_hold);
        end
    endtask

    task automatic test_reset_mid();
        int d;
        stream.delete();
        stream = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h7F, 8'hA5, 8'h05, 8'hCE};
        run_model();
        pulse_start();
        drive(0, 4, 100);
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({in_ready, im_we, im_addr, im_wdata, cpu_hold, done, err} !==
            {1'b0, 1'b0, 12'd0, 19'd0, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL midreset_outputs: rdy/we/addr/wdata/hold/done/err=%b/%b/%h/%h/%b/%b/%b, required 0/0/000/00000/1/0/0",
                     in_ready, im_we, im_addr, im_wdata, cpu_hold, done, err);
        end
        settle();
        @(negedge clk);
        rst = 1'b1;
        settle();
        checks++;
        if (got_q.size() != 0 || in_ready !== 1'b0 || cpu_hold !== 1'b1) begin
            errors++;
            $display("FAIL midreset_idle: writes=%0d rdy=%b hold=%b, required 0/0/1", got_q.size(), in_ready, cpu_hold);
        end
        pulse_start();
        drive(0, exp_n, 100);
        settle();
        d = write_diff(got_q, exp_q);
        checks++;
        if (d != -1 || done !== exp_done) begin
            errors++;
            $display("FAIL midreset_reload: %0d writes first bad %0d done=%b, required %0d writes done=%b",
                     got_q.size(), d, done, exp_q.size(), exp_done);
        end
    endtask

    task automatic test_start_ignored();
        int d;
        build_stream(2, 1'b0);
        run_model();
        pulse_start();
        drive(0, 3, 100);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drive(3, exp_n, 70);
        settle();
        d = write_diff(got_q, exp_q);
        checks++;
        if (d != -1 || done !== 1'b1) begin
            errors++;
            $display("FAIL start_in_word: %0d writes first bad %0d done=%b, required %0d writes done=1",
                     got_q.size(), d, done, exp_q.size());
        end
        @(negedge clk);
        start = 1'b1;
        #1;
        checks++;
        if ({done, cpu_hold} !== 2'b10) begin
            errors++;
            $display("FAIL start_in_done_before: done/hold=%b%b, required 10", done, cpu_hold);
        end
        @(negedge clk);
        start = 1'b0;
        #1;
        checks++;
        if ({done, err, cpu_hold, in_ready} !== 4'b0011) begin
            errors++;
            $display("FAIL start_in_done_after: done/err/hold/rdy=%b%b%b%b, required 0011", done, err, cpu_hold, in_ready);
        end
        apply_reset();
    endtask

    task automatic test_random();
        int d;
        int cnt;
        int duty;
        for (int it = 0; it < 12; it++) begin
            cnt  = int'($urandom_range(6, 1));
            duty = int'($urandom_range(100, 25));
            build_stream(cnt, ($urandom_range(3) == 0));
            if ($urandom_range(7) == 0) stream[1] = stream[1] | 8'h20;
            run_model();
            pulse_start();
            drive(0, exp_n, duty);
            settle();
            d = write_diff(got_q, exp_q);
            checks++;
            if (d != -1) begin
                errors++;
                $display("FAIL random_writes[%0d]: %0d writes first bad %0d, required %0d", it, got_q.size(), d, exp_q.size());
            end
            checks++;
            if ({done, err, cpu_hold, in_ready} !== {exp_done, exp_err, ~exp_done, 1'b0}) begin
                errors++;
                $display("FAIL random_outcome[%0d]: done/err/hold/rdy=%b%b%b%b, required %b%b%b0",
                         it, done, err, cpu_hold, in_ready, exp_done, exp_err, ~exp_done);
            end
        end
    endtask

    task automatic test_max_count();
        int d;
        build_stream(4095, 1'b0);
        run_model();
        pulse_start();
        drive(0, exp_n, 100);
        settle();
        d = write_diff(got_q, exp_q);
        checks++;
        if (d != -1) begin
            errors++;
            $display("FAIL max_count_writes: %0d writes first bad %0d, required %0d", got_q.size(), d, exp_q.size());
        end
        checks++;
        if (im_addr !== 12'd4094 || done !== 1'b1) begin
            errors++;
            $display("FAIL max_count_last: addr=%0d done=%b, required 4094/1", im_addr, done);
        end
    endtask

    initial begin
        test_reset();
        test_spec_vector();
        test_zero_count();
        test_bad_header();
        test_stall();
        test_reset_mid();
        test_start_ignored();
        test_random();
        test_max_count();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
